sfifo_cbb: RTL and testbench
============================

Name: sfifo_cbb

Overview:
- Synchronous single-clock FIFO core feeding fifo_cbb_reg directly.
- Its empty/rdata/ren interface is exactly what the register stage consumes: empty to fifo_empty, rdata to fifo_rdata, reg_fifo_ren to ren.
- Supports "normal" reads (data one cycle after ren) and "ahead" reads (head word visible before ren).
- Provides full/almost-full/almost-empty, an occupancy count and sticky overflow/underflow error flags for the upstream writer and CSR logic.

Parameters:
- FIFO_ATTR, "normal": "normal" means rdata is registered and valid the cycle after an accepted read. "ahead" means rdata always shows the head word.
- FIFO_WIDTH, 8: data width in bits.
- FIFO_DEPTH_WIDTH, 4: address width; depth = 2^FIFO_DEPTH_WIDTH (16).
- AFULL_THD, 12: afull asserts when count >= AFULL_THD.
- AEMPTY_THD, 2: aempty asserts when count <= AEMPTY_THD.

Ports:
- clk_sys  in  1  system clock; all logic is posedge clk_sys.
- reset_n  in  1  asynchronous reset, active-low.
- wen  in  1  write enable.
- wdata  in  FIFO_WIDTH  write data.
- ren  in  1  read enable.
- rdata  out  FIFO_WIDTH  read data.
- full  out  1  1 = FIFO holds 2^FIFO_DEPTH_WIDTH words.
- empty  out  1  1 = FIFO holds 0 words.
- afull  out  1  almost full.
- aempty  out  1  almost empty.
- count  out  FIFO_DEPTH_WIDTH+1  current occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - wr_ptr=rd_ptr=0, count=0.
  - empty=1, aempty=1, full=0, afull=0.
  - overflow=underflow=0, rdata=0.
  - RAM contents are not reset.
- Pointers are FIFO_DEPTH_WIDTH+1 bits. The MSB is a wrap bit. Low bits address the RAM and wrap naturally from 2^N-1 to 0.
- Accepted write: wr_acc = wen & ~full. It writes wdata to RAM[wr_ptr low bits], then wr_ptr+1.
- Accepted read: rd_acc = ren & ~empty. It advances rd_ptr+1.
- Acceptance is judged on the full/empty values present in that cycle, never on same-cycle opposite-port activity:
  - wen while full is dropped even if ren is also asserted.
  - ren while empty is dropped even if wen is also asserted.
- Count update: count <= count + wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Status flags are combinational decodes of the registered count and pointers:
  - full = (wr_ptr MSB != rd_ptr MSB) & (low bits equal).
  - empty = (wr_ptr == rd_ptr).
  - afull = count >= AFULL_THD.
  - aempty = count <= AEMPTY_THD.
  - full/empty must agree with count==2^N / count==0 in every cycle (assertion).
- Write-to-empty-deassert latency: 1 cycle. A write in cycle T gives empty=0 in T+1.
- "normal" read mode:
  - rdata is registered and loads RAM[rd_ptr] on rd_acc.
  - Data is valid in cycle T+1 for rd_acc in T.
  - rdata holds its value when there is no accepted read.
- "ahead" read mode:
  - rdata = RAM[rd_ptr] asynchronously; it is the head word whenever empty=0.
  - After rd_acc in T, rdata shows the next word in T+1.
  - A word written in T appears on rdata in T+1 together with empty=0. RAM write-then-read to the same address returns the new data.
- Sticky errors:
  - overflow <= 1 on wen & full; underflow <= 1 on ren & empty.
  - err_clr clears both. If err_clr coincides with a new error event, the set wins.
- An illegal FIFO_ATTR value is an elaboration error (generate branch with $error).
- Reset mid-operation discards all contents. The first post-reset write lands at RAM address 0.

Decomposition:
- Shared package/header:
  - FIFO_ATTR string constants "normal"/"ahead".
  - Derived localparams: FIFO_DEPTH = 1<<FIFO_DEPTH_WIDTH, PTR_WIDTH = FIFO_DEPTH_WIDTH+1.
- One sub-module: sdp_ram_cbb. It is a simple dual-port RAM with one write port and one read port, parameterised by width, address width and read mode (registered / asynchronous), and is selected by FIFO_ATTR.
- Pointer, count, flag and error logic stay in sfifo_cbb.

Test Plan:
- Reset, then write 0x01..0x10 with no reads -> count 1..16. afull rises when count=12. full=1 after the 16th write; a 17th wen sets overflow=1 and count stays 16.
- Then read 16 times (normal mode) -> rdata 0x01..0x10, each one cycle after its ren. empty=1 after the last read. An extra ren sets underflow=1 and rdata holds 0x10.
- Ahead mode, write 0xA5 in cycle T -> in T+1 empty=0 and rdata=0xA5 with no ren. After ren in T+1, empty=1 in T+2.
- Steady-state streaming: count=5, wen&ren every cycle for 40 cycles with incrementing data -> count stays 5 and ordering is preserved across a pointer wrap. No overflow or underflow.
- Empty FIFO with wen&ren in the same cycle -> write accepted, read dropped: count=1, underflow=1. Same test with a full FIFO -> read accepted, write dropped: count=15, overflow=1.
- Assert reset_n=0 asynchronously mid-stream with count=9 -> empty=1, count=0 and flags cleared immediately. Next write of 0x3C reads back 0x3C. err_clr coinciding with an overflow event leaves overflow=1.

Source files
------------

// File: rtl/sfifo_cbb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_cbb_pkg
// Description : Shared constants, read-mode type and sizing helpers for sfifo_cbb.
// Revision    : 1.0 - initial release
// ============================================================================
package sfifo_cbb_pkg;

  // FIFO_ATTR values, zero-extended to a fixed width so they compare cleanly
  localparam int          C_ATTR_BITS   = 64;
  localparam logic [63:0] C_ATTR_NORMAL = 64'("normal");
  localparam logic [63:0] C_ATTR_AHEAD  = 64'("ahead");

  typedef enum logic {
    RD_REG   = 1'b0,
    RD_ASYNC = 1'b1
  } rd_mode_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit attr_match(input logic [63:0] attr, input logic [63:0] ref_attr);
    return attr == ref_attr;
  endfunction

endpackage : sfifo_cbb_pkg
`default_nettype wire

// File: rtl/sdp_ram_cbb.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram_cbb
// Description : Simple dual-port RAM, one write port, one registered or async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram_cbb
  import sfifo_cbb_pkg::*;
#(
  parameter int       WIDTH      = 8,
  parameter int       ADDR_WIDTH = 4,
  parameter rd_mode_e RD_MODE    = RD_REG
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int C_WORDS = 1 << ADDR_WIDTH;

  // Storage is deliberately not reset so it can map onto RAM macros
  logic [WIDTH-1:0] r_mem [0:C_WORDS-1];

  always_ff @(posedge clk_sys) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  generate
    if (RD_MODE == RD_REG) begin : g_rd_reg
      logic [WIDTH-1:0] r_rdata;

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          r_rdata <= '0;
        end else if (re) begin
          r_rdata <= r_mem[raddr];
        end
      end

      assign rdata = r_rdata;
    end else begin : g_rd_async
      logic w_unused_async;

      assign w_unused_async = &{1'b0, re, reset_n};
      assign rdata          = r_mem[raddr];
    end
  endgenerate

endmodule : sdp_ram_cbb
`default_nettype wire

// File: rtl/sfifo_cbb.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_cbb
// Description : Single-clock FIFO with normal/ahead read, level flags and sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module sfifo_cbb
  import sfifo_cbb_pkg::*;
#(
  parameter     FIFO_ATTR        = "normal",
  parameter int FIFO_WIDTH       = 8,
  parameter int FIFO_DEPTH_WIDTH = 4,
  parameter int AFULL_THD        = 12,
  parameter int AEMPTY_THD       = 2
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      wen,
  input  logic [FIFO_WIDTH-1:0]     wdata,
  input  logic                      ren,
  output logic [FIFO_WIDTH-1:0]     rdata,
  output logic                      full,
  output logic                      empty,
  output logic                      afull,
  output logic                      aempty,
  output logic [FIFO_DEPTH_WIDTH:0] count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      err_clr
);

  localparam int FIFO_DEPTH = fifo_depth(FIFO_DEPTH_WIDTH);
  localparam int PTR_WIDTH  = ptr_width(FIFO_DEPTH_WIDTH);

  localparam bit       C_IS_NORMAL = attr_match(C_ATTR_BITS'(FIFO_ATTR), C_ATTR_NORMAL);
  localparam bit       C_IS_AHEAD  = attr_match(C_ATTR_BITS'(FIFO_ATTR), C_ATTR_AHEAD);
  localparam rd_mode_e C_RD_MODE   = C_IS_AHEAD ? RD_ASYNC : RD_REG;

  localparam logic [PTR_WIDTH-1:0] C_FULL_CNT   = PTR_WIDTH'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] C_AFULL_THD  = PTR_WIDTH'(AFULL_THD);
  localparam logic [PTR_WIDTH-1:0] C_AEMPTY_THD = PTR_WIDTH'(AEMPTY_THD);

  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH-1:0]  r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [FIFO_WIDTH-1:0] w_ram_rdata;

  // Same-depth pointers with an extra wrap bit distinguish full from empty
  assign w_full  = (r_wr_ptr[PTR_WIDTH-1] != r_rd_ptr[PTR_WIDTH-1]) &&
                   (r_wr_ptr[PTR_WIDTH-2:0] == r_rd_ptr[PTR_WIDTH-2:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_wr_acc = wen & ~w_full;
  assign w_rd_acc = ren & ~w_empty;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
      r_count <= r_count + PTR_WIDTH'(w_wr_acc) - PTR_WIDTH'(w_rd_acc);
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wen && w_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (ren && w_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  sdp_ram_cbb #(
    .WIDTH      (FIFO_WIDTH),
    .ADDR_WIDTH (FIFO_DEPTH_WIDTH),
    .RD_MODE    (C_RD_MODE)
  ) u_ram (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .we      (w_wr_acc),
    .waddr   (r_wr_ptr[PTR_WIDTH-2:0]),
    .wdata   (wdata),
    .re      (w_rd_acc),
    .raddr   (r_rd_ptr[PTR_WIDTH-2:0]),
    .rdata   (w_ram_rdata)
  );

  generate
    if (C_IS_NORMAL) begin : g_normal
      assign rdata = w_ram_rdata;
    end else if (C_IS_AHEAD) begin : g_ahead
      // Hide uninitialised RAM contents while there is no head word
      assign rdata = w_empty ? '0 : w_ram_rdata;
    end else begin : g_bad_attr
      $error("sfifo_cbb: FIFO_ATTR must be \"normal\" or \"ahead\"");
      assign rdata = '0;
    end
  endgenerate

  assign full      = w_full;
  assign empty     = w_empty;
  assign afull     = (r_count >= C_AFULL_THD);
  assign aempty    = (r_count <= C_AEMPTY_THD);
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  a_flags_match_count: assert property (
    @(posedge clk_sys) disable iff (!reset_n)
    (w_full == (r_count == C_FULL_CNT)) && (w_empty == (r_count == '0))
  );

endmodule : sfifo_cbb
`default_nettype wire

// File: tb/tb_sfifo_cbb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfifo_cbb
// Description : Directed bench driving a normal-mode and an ahead-mode FIFO in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfifo_cbb;

  logic       clk_sys;
  logic       reset_n;
  logic       wen;
  logic [7:0] wdata;
  logic       ren;
  logic       err_clr;

  logic [7:0] rdata_n,  rdata_a;
  logic       full_n,   full_a;
  logic       empty_n,  empty_a;
  logic       afull_n,  afull_a;
  logic       aempty_n, aempty_a;
  logic [4:0] count_n,  count_a;
  logic       ovf_n,    ovf_a;
  logic       udf_n,    udf_a;

  int n_vec;
  int n_err;

  sfifo_cbb #(
    .FIFO_ATTR ("normal"), .FIFO_WIDTH (8), .FIFO_DEPTH_WIDTH (4),
    .AFULL_THD (12), .AEMPTY_THD (2)
  ) u_norm (
    .clk_sys (clk_sys), .reset_n (reset_n), .wen (wen), .wdata (wdata),
    .ren (ren), .rdata (rdata_n), .full (full_n), .empty (empty_n),
    .afull (afull_n), .aempty (aempty_n), .count (count_n),
    .overflow (ovf_n), .underflow (udf_n), .err_clr (err_clr)
  );

  sfifo_cbb #(
    .FIFO_ATTR ("ahead"), .FIFO_WIDTH (8), .FIFO_DEPTH_WIDTH (4),
    .AFULL_THD (12), .AEMPTY_THD (2)
  ) u_ahead (
    .clk_sys (clk_sys), .reset_n (reset_n), .wen (wen), .wdata (wdata),
    .ren (ren), .rdata (rdata_a), .full (full_a), .empty (empty_a),
    .afull (afull_a), .aempty (aempty_a), .count (count_a),
    .overflow (ovf_a), .underflow (udf_a), .err_clr (err_clr)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    wen     = 1'b0;
    ren     = 1'b0;
    wdata   = 8'h00;
    err_clr = 1'b0;
    repeat (2) tick();

    chk("rst_empty",  32'(empty_n),  32'd1);
    chk("rst_aempty", 32'(aempty_n), 32'd1);
    chk("rst_full",   32'(full_n),   32'd0);
    chk("rst_afull",  32'(afull_n),  32'd0);
    chk("rst_count",  32'(count_n),  32'd0);
    chk("rst_ovf",    32'(ovf_n),    32'd0);
    chk("rst_udf",    32'(udf_n),    32'd0);
    chk("rst_rdata",  32'(rdata_n),  32'd0);
    chk("rst_empty_a", 32'(empty_a), 32'd1);
    reset_n = 1'b1;

    // Fill to full, checking level flags at every step
    for (int i = 1; i <= 16; i++) begin
      wen = 1'b1; wdata = 8'(i);
      tick();
      chk("fill_count",  32'(count_n),  32'(i));
      chk("fill_afull",  32'(afull_n),  32'(i >= 12));
      chk("fill_full",   32'(full_n),   32'(i == 16));
      chk("fill_aempty", 32'(aempty_n), 32'(i <= 2));
      chk("fill_head_a", 32'(rdata_a),  32'h01);
    end
    wdata = 8'h11;
    tick();
    wen = 1'b0;
    chk("ovf_set",    32'(ovf_n),   32'd1);
    chk("ovf_count",  32'(count_n), 32'd16);
    chk("ovf_full",   32'(full_n),  32'd1);
    chk("ovf_no_udf", 32'(udf_n),   32'd0);
    chk("ovf_set_a",  32'(ovf_a),   32'd1);

    for (int i = 1; i <= 16; i++) begin
      chk("drain_head_a", 32'(rdata_a), 32'(i));
      ren = 1'b1;
      tick();
      chk("drain_rdata", 32'(rdata_n), 32'(i));
    end
    ren = 1'b0;
    chk("drain_empty", 32'(empty_n), 32'd1);
    chk("drain_count", 32'(count_n), 32'd0);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("udf_set",   32'(udf_n),   32'd1);
    chk("udf_hold",  32'(rdata_n), 32'h10);
    chk("udf_count", 32'(count_n), 32'd0);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ovf", 32'(ovf_n), 32'd0);
    chk("clr_udf", 32'(udf_n), 32'd0);

    // Ahead mode: word visible the cycle after its write, without ren
    wen = 1'b1; wdata = 8'hA5;
    tick();
    wen = 1'b0;
    chk("ahead_empty", 32'(empty_a), 32'd0);
    chk("ahead_rdata", 32'(rdata_a), 32'hA5);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("ahead_empty_after", 32'(empty_a), 32'd1);
    chk("ahead_norm_rdata",  32'(rdata_n), 32'hA5);

    // Streaming at count 5 across a pointer wrap
    for (int k = 0; k < 5; k++) begin
      wen = 1'b1; wdata = 8'(8'h20 + k);
      tick();
    end
    wen = 1'b0;
    chk("stream_pre_count", 32'(count_n), 32'd5);
    for (int k = 0; k < 40; k++) begin
      chk("stream_head_a", 32'(rdata_a), 32'(8'h20 + k));
      wen = 1'b1; ren = 1'b1; wdata = 8'(8'h25 + k);
      tick();
      chk("stream_count", 32'(count_n), 32'd5);
      chk("stream_rdata", 32'(rdata_n), 32'(8'h20 + k));
    end
    wen = 1'b0; ren = 1'b0;
    chk("stream_ovf", 32'(ovf_n), 32'd0);
    chk("stream_udf", 32'(udf_n), 32'd0);
    for (int k = 40; k < 45; k++) begin
      chk("tail_head_a", 32'(rdata_a), 32'(8'h20 + k));
      ren = 1'b1;
      tick();
      chk("tail_rdata", 32'(rdata_n), 32'(8'h20 + k));
    end
    ren = 1'b0;
    chk("tail_empty", 32'(empty_n), 32'd1);

    // Simultaneous wen/ren on empty: write wins, read dropped
    wen = 1'b1; ren = 1'b1; wdata = 8'h77;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("emp_wr_count", 32'(count_n), 32'd1);
    chk("emp_wr_udf",   32'(udf_n),   32'd1);
    chk("emp_wr_hold",  32'(rdata_n), 32'h4C);
    chk("emp_wr_head_a", 32'(rdata_a), 32'h77);

    for (int k = 1; k <= 15; k++) begin
      wen = 1'b1; wdata = 8'(8'h80 + k);
      tick();
    end
    wen = 1'b0;
    chk("refill_full", 32'(full_n), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Simultaneous wen/ren on full: read wins, write dropped
    wen = 1'b1; ren = 1'b1; wdata = 8'hEE;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("full_rd_count", 32'(count_n), 32'd15);
    chk("full_rd_ovf",   32'(ovf_n),   32'd1);
    chk("full_rd_udf",   32'(udf_n),   32'd0);
    chk("full_rd_rdata", 32'(rdata_n), 32'h77);
    chk("full_rd_head_a", 32'(rdata_a), 32'h81);

    for (int k = 1; k <= 6; k++) begin
      ren = 1'b1;
      tick();
      chk("pre_rst_rdata", 32'(rdata_n), 32'(8'h80 + k));
    end
    ren = 1'b0;
    chk("pre_rst_count", 32'(count_n), 32'd9);

    // Asynchronous reset in the middle of a streaming cycle
    wen = 1'b1; ren = 1'b1; wdata = 8'h99;
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_count",  32'(count_n),  32'd0);
    chk("arst_empty",  32'(empty_n),  32'd1);
    chk("arst_full",   32'(full_n),   32'd0);
    chk("arst_afull",  32'(afull_n),  32'd0);
    chk("arst_aempty", 32'(aempty_n), 32'd1);
    chk("arst_ovf",    32'(ovf_n),    32'd0);
    chk("arst_rdata",  32'(rdata_n),  32'd0);
    chk("arst_rdata_a", 32'(rdata_a), 32'd0);
    wen = 1'b0; ren = 1'b0;
    #1;
    reset_n = 1'b1;

    wen = 1'b1; wdata = 8'h3C;
    tick();
    wen = 1'b0;
    chk("post_rst_count",  32'(count_n), 32'd1);
    chk("post_rst_head_a", 32'(rdata_a), 32'h3C);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("post_rst_rdata", 32'(rdata_n), 32'h3C);

    // err_clr coinciding with an overflow event: set wins
    for (int k = 0; k < 16; k++) begin
      wen = 1'b1; wdata = 8'(k);
      tick();
    end
    err_clr = 1'b1;
    tick();
    wen = 1'b0; err_clr = 1'b0;
    chk("clr_vs_ovf", 32'(ovf_n), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_after", 32'(ovf_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sfifo_cbb
`default_nettype wire
